// File: rtl/piso_reg.sv
// UART-Tx parallel-in/serial-out stage: shifts an 11-bit pre-built frame LSB-first, one bit per baud edge.
// Optional build macro PISO_PARITY_REGEN_EN recomputes the parity bit from the latched data bits.
module piso_reg (
    input  logic        BaudOut,
    input  logic        rst,
    input  logic [10:0] frame_out,
    input  logic [1:0]  parity_type,
    input  logic        stop_bits,
    input  logic        data_length,
    input  logic        send,
    output logic        data_out,
    output logic        p_parity_out,
    output logic        tx_active,
    output logic        tx_done
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    logic [1:0]  r_state;
    logic [10:0] r_frame;
    logic [3:0]  r_len;
    logic [3:0]  r_cnt;
    logic        r_data_out;
    logic        r_parity;
    logic        r_tx_active;
    logic        r_tx_done;

    logic        w_par_en;
    logic [3:0]  w_par_idx;
    logic [3:0]  w_len_raw;
    logic [3:0]  w_len;
    logic        w_par_bit;
    logic [10:0] w_frame_ld;
    logic        w_start;

    assign w_par_en  = (parity_type == 2'b01) || (parity_type == 2'b10);
    assign w_par_idx = data_length ? 4'd9 : 4'd8;
    assign w_len_raw = 4'd1 + (data_length ? 4'd8 : 4'd7) + {3'b000, w_par_en}
                     + (stop_bits ? 4'd2 : 4'd1);
    // 8 data + parity + 2 stop would need 12 bits; the second stop bit is dropped
    assign w_len     = (w_len_raw > 4'd11) ? 4'd11 : w_len_raw;

`ifdef PISO_PARITY_REGEN_EN
    logic [7:0] w_data_bits;

    assign w_data_bits = data_length ? frame_out[8:1] : {1'b0, frame_out[7:1]};
    assign w_par_bit   = (parity_type == 2'b01) ? ~(^w_data_bits) : (^w_data_bits);

    always_comb begin
        w_frame_ld = frame_out;
        if (w_par_en)
            w_frame_ld[w_par_idx] = w_par_bit;
    end
`else
    assign w_par_bit  = frame_out[w_par_idx];
    assign w_frame_ld = frame_out;
`endif

    // The edge leaving DONE already behaves as IDLE, so a held send gives a one-period gap
    assign w_start = send && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge BaudOut) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_data_out  <= 1'b1;
            r_parity    <= 1'b0;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (r_cnt < r_len) begin
                        r_data_out <= r_frame[r_cnt];
                        r_cnt      <= r_cnt + 4'd1;
                    end else begin
                        r_state     <= ST_DONE;
                        r_cnt       <= 4'd0;
                        r_data_out  <= 1'b1;
                        r_tx_active <= 1'b0;
                        r_tx_done   <= 1'b1;
                    end
                end
                default: begin
                    r_tx_done <= 1'b0;
                    if (w_start) begin
                        r_state     <= ST_SHIFT;
                        r_frame     <= w_frame_ld;
                        r_len       <= w_len;
                        r_cnt       <= 4'd1;
                        r_data_out  <= w_frame_ld[0];
                        r_tx_active <= 1'b1;
                        r_parity    <= w_par_en ? w_par_bit : 1'b0;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_data_out  <= 1'b1;
                        r_tx_active <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign data_out     = r_data_out;
    assign p_parity_out = r_parity;
    assign tx_active    = r_tx_active;
    assign tx_done      = r_tx_done;

endmodule

// File: tb/tb_piso_reg.sv
// Randomized bench for piso_reg against a frame-level reference model.
module tb_piso_reg;

    logic        BaudOut = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] frame_out = '0;
    logic [1:0]  parity_type = '0;
    logic        stop_bits = 1'b0;
    logic        data_length = 1'b0;
    logic        send = 1'b0;
    logic        data_out;
    logic        p_parity_out;
    logic        tx_active;
    logic        tx_done;

    int n_chk = 0;
    int n_pass = 0;

    piso_reg dut (
        .BaudOut      (BaudOut),
        .rst          (rst),
        .frame_out    (frame_out),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .data_length  (data_length),
        .send         (send),
        .data_out     (data_out),
        .p_parity_out (p_parity_out),
        .tx_active    (tx_active),
        .tx_done      (tx_done)
    );

    always #5 BaudOut = ~BaudOut;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic bit m_has_par(input logic [1:0] pt);
        return (pt == 2'b01) || (pt == 2'b10);
    endfunction

    function automatic int m_len(input logic dl, input logic [1:0] pt, input logic sb);
        int n;
        n = 1 + (dl ? 8 : 7) + (m_has_par(pt) ? 1 : 0) + (sb ? 2 : 1);
        return (n > 11) ? 11 : n;
    endfunction

    function automatic logic m_par(input logic [10:0] f, input logic dl, input logic [1:0] pt);
        int d;
        int ones;
        d = dl ? 8 : 7;
        ones = 0;
        if (!m_has_par(pt)) return 1'b0;
`ifdef PISO_PARITY_REGEN_EN
        for (int i = 1; i <= d; i++) ones += int'(f[i]);
        if (pt == 2'b01) return (ones % 2) == 0;
        return (ones % 2) == 1;
`else
        return f[d + 1];
`endif
    endfunction

    function automatic logic m_bit(input logic [10:0] f, input logic dl, input logic [1:0] pt, input int k);
        int d;
        d = dl ? 8 : 7;
        if (m_has_par(pt) && k == d + 1) return m_par(f, dl, pt);
        return f[k];
    endfunction

    // Called at a negedge; the frame starts on the following posedge.
    task automatic do_frame(input logic [10:0] f, input logic [1:0] pt, input logic sb,
                            input logic dl, input bit b2b_next, input int abort_at);
        int  n;
        logic ep;
        n  = m_len(dl, pt, sb);
        ep = m_par(f, dl, pt);
        frame_out = f; parity_type = pt; stop_bits = sb; data_length = dl; send = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge BaudOut); #1;
            check_eq($sformatf("bit%0d", k), data_out, m_bit(f, dl, pt, k));
            check_eq("active", tx_active, 1'b1);
            check_eq("done_low", tx_done, 1'b0);
            check_eq("parity", p_parity_out, ep);
            @(negedge BaudOut);
            if (k == abort_at) begin
                rst = 1'b0;
                @(posedge BaudOut); #1;
                check_eq("abort_data", data_out, 1'b1);
                check_eq("abort_active", tx_active, 1'b0);
                check_eq("abort_done", tx_done, 1'b0);
                check_eq("abort_par", p_parity_out, 1'b0);
                @(negedge BaudOut);
                rst = 1'b1; send = 1'b0;
                @(posedge BaudOut); #1;
                check_eq("abort_nodone", tx_done, 1'b0);
                check_eq("abort_idle", data_out, 1'b1);
                @(negedge BaudOut);
                return;
            end
            frame_out = 11'($urandom); parity_type = 2'($urandom);
            stop_bits = 1'($urandom); data_length = 1'($urandom); send = 1'($urandom);
        end
        @(posedge BaudOut); #1;
        check_eq("done_data", data_out, 1'b1);
        check_eq("done_active", tx_active, 1'b0);
        check_eq("done_pulse", tx_done, 1'b1);
        check_eq("done_par", p_parity_out, ep);
        @(negedge BaudOut);
        if (!b2b_next) begin
            send = 1'b0;
            @(posedge BaudOut); #1;
            check_eq("idle_data", data_out, 1'b1);
            check_eq("idle_active", tx_active, 1'b0);
            check_eq("idle_done", tx_done, 1'b0);
            check_eq("idle_par", p_parity_out, ep);
            @(negedge BaudOut);
        end
    endtask

    initial begin
        bit b2b;
        rst = 1'b0;
        send = 1'b0;
        repeat (2) @(posedge BaudOut);
        #1;
        check_eq("rst_data", data_out, 1'b1);
        check_eq("rst_active", tx_active, 1'b0);
        check_eq("rst_done", tx_done, 1'b0);
        check_eq("rst_par", p_parity_out, 1'b0);
        @(negedge BaudOut);
        rst = 1'b1;

        do_frame(11'b11010010100, 2'b00, 1'b0, 1'b1, 1'b0, -1);
        do_frame(11'b11010010100, 2'b01, 1'b0, 1'b1, 1'b0, -1);
        do_frame(11'b11011001010, 2'b00, 1'b1, 1'b0, 1'b0, -1);
        do_frame(11'h5A5,         2'b10, 1'b1, 1'b1, 1'b0, -1);
        do_frame(11'b11010010100, 2'b00, 1'b0, 1'b1, 1'b1, -1);
        do_frame(11'b11011001010, 2'b10, 1'b0, 1'b0, 1'b1, -1);
        do_frame(11'h6D3,         2'b01, 1'b1, 1'b1, 1'b0, -1);
        do_frame(11'b11010010100, 2'b00, 1'b0, 1'b1, 1'b0, 4);

        for (int i = 0; i < 40; i++) begin
            b2b = (i < 39) && ($urandom_range(0, 2) == 0);
            do_frame(11'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), b2b,
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
